associative_tagged_array: RTL and testbench
===========================================

// Module: associative_tagged_array
// PURPOSE
//  Tagged N-way set-associative storage: tag/valid lookup, hit detection, masked write on hit,
//  victim allocation on write-miss, and a sequential whole-array invalidate. Successor to the
//  untagged way-select array; cache and TLB controllers use it as their data/tag backing store.
// PARAMETERS
//  SINGLE_ENTRY_SIZE_IN_BITS  64            data bits per way entry (multiple of 8)
//  NUM_SET                    64            sets, power of two >= 2
//  NUM_WAY                    4             ways, power of two >= 2
//  TAG_WIDTH_IN_BITS          20            tag bits per entry
//  SET_PTR_WIDTH_IN_BITS      $clog2(NUM_SET)
//  WAY_PTR_WIDTH_IN_BITS      $clog2(NUM_WAY)
//  WRITE_MASK_LEN             SINGLE_ENTRY_SIZE_IN_BITS/8   byte-enable width
// PORTS
//  clk_in                 in   1        clock, all state on rising edge
//  reset_n_in             in   1        asynchronous, active-low reset
//  flush_in               in   1        pulse: invalidate every entry
//  req_valid_in           in   1        request valid
//  req_ready_out          out  1        request accepted when valid & ready
//  req_write_in           in   1        1 = write, 0 = lookup
//  req_write_mask_in      in   WRITE_MASK_LEN           byte enables for write
//  req_set_addr_in        in   SET_PTR_WIDTH_IN_BITS    set index
//  req_tag_in             in   TAG_WIDTH_IN_BITS        tag to match / install
//  req_data_in            in   SINGLE_ENTRY_SIZE_IN_BITS write data
//  resp_valid_out         out  1        one-cycle response strobe
//  resp_hit_out           out  1        tag matched a valid way
//  resp_way_out           out  WAY_PTR_WIDTH_IN_BITS    hit way, or allocated way on write-miss
//  resp_data_out          out  SINGLE_ENTRY_SIZE_IN_BITS hit-way data (lookup), else 0
//  resp_evict_valid_out   out  1        write-miss replaced a valid entry
//  resp_evict_tag_out     out  TAG_WIDTH_IN_BITS        tag of replaced entry
// BEHAVIOUR
//  - Reset: state=FLUSH, sweep ptr=0, req_ready_out=0, all resp_* outputs 0, RR ptrs 0.
//  - FSM IDLE/FLUSH. FLUSH clears valid bits of set sweep_ptr each cycle, ptr+1; after set
//    NUM_SET-1 -> IDLE (exactly NUM_SET cycles). req_ready_out = (state==IDLE).
//  - IDLE & flush_in -> FLUSH next cycle; a request accepted the same cycle completes first.
//    flush_in during FLUSH ignored. Reset mid-sweep restarts at set 0.
//  - Tags/valid in flops, compared combinationally at acceptance cycle T; data in per-way RAM.
//  - Lookup accepted at T: resp_valid_out=1 at T+1 only; hit/way/data valid then; miss -> data 0.
//  - Write-hit at T: masked bytes of hit way written at edge T; tag/valid unchanged.
//  - Write-miss at T: victim = lowest-index invalid way, else set's RR pointer (then ptr+1 mod
//    NUM_WAY). Tag installed, valid=1, masked bytes written, unmasked bytes written 0.
//    resp_evict_valid_out/tag_out report the old entry at T+1; 0 otherwise.
//  - RR pointer changes only on write-miss into a full set.
//  - Back-to-back: lookup at T+1 to an entry written at T returns the new data (no stall).
//  - Multiple-way tag match is illegal (assert); responses not cancelled by flush_in.
//  - Full throughput: one request per cycle in IDLE; no back-pressure on responses.
// TESTING
//  1 Reset, hold req_valid_in: req_ready_out=0 for 64 cycles, 1 on cycle 65; lookup -> hit=0.
//  2 Write set 5 tag 0x123 mask 0xFF data 0xA5A5..; lookup next cycle -> hit=1, way=0, data 0xA5A5...
//  3 Write-hit mask 0x01 data 0x..FF on it -> lookup data 0xA5A5_A5A5_A5A5_A5FF.
//  4 Fill set 7 with tags 1..4 (ways 0..3), write tag 5 -> way 0, evict_valid=1, evict_tag=1;
//    tag 6 -> way 1, evict_tag=2.
//  5 flush_in with concurrent write: write takes effect, then 64 not-ready cycles, all lookups miss.
//  6 Deassert reset_n_in mid-flush at sweep ptr 30 -> sweep restarts at 0, ready after 64 cycles.

Source files
------------

// File: rtl/associative_tagged_array.sv
// associative_tagged_array
//   Tagged N-way set-associative storage used as the tag/data backing store of
//   cache and TLB controllers. Tags and valid bits live in flops and are
//   matched combinationally in the cycle a request is accepted. Entry data
//   lives in a per-way RAM. A whole-array invalidate sweeps one set per cycle.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | accepting one request per cycle (req_ready_out = 1)
//   ST_FLUSH | clearing valid bits of set sweep_q, one set per cycle; not ready
//
// Ports
//   clk_in, reset_n_in       clock, asynchronous active-low reset
//   flush_in                 pulse: invalidate every entry (honoured in IDLE)
//   req_valid_in/ready_out   request handshake
//   req_write_in             1 = masked write, 0 = lookup
//   req_write_mask_in        byte enables
//   req_set_addr_in          set index
//   req_tag_in               tag to match / install
//   req_data_in              write data
//   resp_valid_out           one-cycle strobe, one cycle after acceptance
//   resp_hit_out             tag matched a valid way
//   resp_way_out             hit way, or allocated way on write-miss
//   resp_data_out            hit-way data on lookup, else 0
//   resp_evict_valid_out     write-miss replaced a valid entry
//   resp_evict_tag_out       tag of the replaced entry
module associative_tagged_array #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int NUM_WAY                   = 4,
  parameter int TAG_WIDTH_IN_BITS         = 20,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WAY_PTR_WIDTH_IN_BITS     = $clog2(NUM_WAY),
  parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / 8
) (
  input  logic                                 clk_in,
  input  logic                                 reset_n_in,
  input  logic                                 flush_in,
  input  logic                                 req_valid_in,
  output logic                                 req_ready_out,
  input  logic                                 req_write_in,
  input  logic [WRITE_MASK_LEN-1:0]            req_write_mask_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     req_set_addr_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]         req_tag_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_data_in,
  output logic                                 resp_valid_out,
  output logic                                 resp_hit_out,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0]     resp_way_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_data_out,
  output logic                                 resp_evict_valid_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]         resp_evict_tag_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                               state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     sweep_q;
  logic [NUM_WAY-1:0]                   valid_q  [NUM_SET];
  logic [TAG_WIDTH_IN_BITS-1:0]         tag_q    [NUM_SET][NUM_WAY];
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     rr_q     [NUM_SET];
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_mem [NUM_WAY][NUM_SET];

  logic                                 accept;
  logic                                 sweep_last;
  logic [NUM_WAY-1:0]                   set_valid;
  logic [NUM_WAY-1:0]                   match_vec;
  logic                                 hit;
  logic                                 set_full;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     hit_way;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     first_invalid;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     victim_way;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     wr_way;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]     resp_way_d;
  logic                                 wr_en;
  logic                                 wr_miss;
  logic                                 evict;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mask_bits;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] wr_data;
  logic [WRITE_MASK_LEN-1:0]            wr_be;

  assign req_ready_out = (state_q == ST_IDLE);
  assign accept        = req_valid_in & req_ready_out;
  assign sweep_last    = (sweep_q == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1));
  assign set_valid     = valid_q[req_set_addr_in];

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    match_vec     = '0;
    hit_way       = '0;
    first_invalid = '0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      match_vec[w] = set_valid[w] && (tag_q[req_set_addr_in][w] == req_tag_in);
      if (match_vec[w]) hit_way = WAY_PTR_WIDTH_IN_BITS'(w);
      if (!set_valid[w]) first_invalid = WAY_PTR_WIDTH_IN_BITS'(w);
    end
  end

  assign hit        = |match_vec;
  assign set_full   = &set_valid;
  assign victim_way = set_full ? rr_q[req_set_addr_in] : first_invalid;
  assign wr_en      = accept & req_write_in;
  assign wr_miss    = wr_en & ~hit;
  assign evict      = wr_miss & set_full;
  assign wr_way     = hit ? hit_way : victim_way;
  assign resp_way_d = hit ? hit_way : (req_write_in ? victim_way : '0);

  always_comb begin
    mask_bits = '0;
    for (int b = 0; b < WRITE_MASK_LEN; b++) begin
      mask_bits[b*8 +: 8] = {8{req_write_mask_in[b]}};
    end
  end

  // A freshly allocated entry must not inherit stale bytes: on a miss every
  // byte is written, with unmasked bytes forced to zero.
  assign wr_data = wr_miss ? (req_data_in & mask_bits) : req_data_in;
  assign wr_be   = wr_miss ? '1 : req_write_mask_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_in) state_d = ST_FLUSH;
      ST_FLUSH: if (sweep_last) state_d = ST_IDLE;
      default:  state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_FLUSH;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      // Wraps back to 0 after the last set, ready for the next sweep.
      if (state_q == ST_FLUSH) sweep_q <= sweep_q + SET_PTR_WIDTH_IN_BITS'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int s = 0; s < NUM_SET; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < NUM_WAY; w++) tag_q[s][w] <= '0;
      end
    end else begin
      if (state_q == ST_FLUSH) valid_q[sweep_q] <= '0;
      if (wr_miss) begin
        valid_q[req_set_addr_in][victim_way] <= 1'b1;
        tag_q[req_set_addr_in][victim_way]   <= req_tag_in;
        if (set_full) rr_q[req_set_addr_in] <= rr_q[req_set_addr_in] + WAY_PTR_WIDTH_IN_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      for (int b = 0; b < WRITE_MASK_LEN; b++) begin
        if (wr_be[b]) data_mem[wr_way][req_set_addr_in][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      resp_valid_out       <= 1'b0;
      resp_hit_out         <= 1'b0;
      resp_way_out         <= '0;
      resp_data_out        <= '0;
      resp_evict_valid_out <= 1'b0;
      resp_evict_tag_out   <= '0;
    end else begin
      resp_valid_out       <= accept;
      resp_hit_out         <= accept & hit;
      resp_way_out         <= accept ? resp_way_d : '0;
      resp_data_out        <= (accept && hit && !req_write_in) ?
                              data_mem[hit_way][req_set_addr_in] : '0;
      resp_evict_valid_out <= evict;
      resp_evict_tag_out   <= evict ? tag_q[req_set_addr_in][victim_way] : '0;
    end
  end

  // Writes only install tags that missed, so a set can never hold duplicates.
  assert property (@(posedge clk_in) disable iff (!reset_n_in)
                   accept |-> $onehot0(match_vec));

endmodule

// File: tb/tb_associative_tagged_array.sv
module tb_associative_tagged_array;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        flush_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [7:0]  req_write_mask_in;
  logic [5:0]  req_set_addr_in;
  logic [19:0] req_tag_in;
  logic [63:0] req_data_in;
  logic        resp_valid_out;
  logic        resp_hit_out;
  logic [1:0]  resp_way_out;
  logic [63:0] resp_data_out;
  logic        resp_evict_valid_out;
  logic [19:0] resp_evict_tag_out;

  associative_tagged_array dut (
    .clk_in              (clk_in),
    .reset_n_in          (reset_n_in),
    .flush_in            (flush_in),
    .req_valid_in        (req_valid_in),
    .req_ready_out       (req_ready_out),
    .req_write_in        (req_write_in),
    .req_write_mask_in   (req_write_mask_in),
    .req_set_addr_in     (req_set_addr_in),
    .req_tag_in          (req_tag_in),
    .req_data_in         (req_data_in),
    .resp_valid_out      (resp_valid_out),
    .resp_hit_out        (resp_hit_out),
    .resp_way_out        (resp_way_out),
    .resp_data_out       (resp_data_out),
    .resp_evict_valid_out(resp_evict_valid_out),
    .resp_evict_tag_out  (resp_evict_tag_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          hit;
    int          way;
    logic [63:0] data;
    bit          ev;
    logic [19:0] evt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: per-set list of entries, replacement by the documented rules.
  bit          m_valid [64][4];
  logic [19:0] m_tag   [64][4];
  logic [63:0] m_data  [64][4];
  int          m_rr    [64];

  bit          last_hit;
  int          last_way;
  logic [63:0] last_data;
  bit          last_ev;
  logic [19:0] last_evt;

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_step(input bit wr, input logic [7:0] mask, input int set,
                            input logic [19:0] tag, input logic [63:0] data,
                            output exp_t e);
    int hw;
    int v;
    logic [63:0] em;
    e.hit = 0; e.way = 0; e.data = '0; e.ev = 0; e.evt = '0;
    em = expand(mask);
    hw = -1;
    for (int w = 0; w < 4; w++)
      if (hw < 0 && m_valid[set][w] && m_tag[set][w] == tag) hw = w;
    if (hw >= 0) begin
      e.hit = 1;
      e.way = hw;
      if (!wr) e.data = m_data[set][hw];
      else     m_data[set][hw] = (m_data[set][hw] & ~em) | (data & em);
    end else if (wr) begin
      v = -1;
      for (int w = 0; w < 4; w++) if (v < 0 && !m_valid[set][w]) v = w;
      if (v < 0) begin
        v = m_rr[set];
        e.ev = 1;
        e.evt = m_tag[set][v];
        m_rr[set] = (m_rr[set] + 1) % 4;
      end
      e.way = v;
      m_valid[set][v] = 1'b1;
      m_tag[set][v]   = tag;
      m_data[set][v]  = data & em;
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (reset_n_in && resp_valid_out) begin
      last_hit  = resp_hit_out;
      last_way  = int'(resp_way_out);
      last_data = resp_data_out;
      last_ev   = resp_evict_valid_out;
      last_evt  = resp_evict_tag_out;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got a response with no request outstanding");
      end else begin
        e = exp_q.pop_front();
        if (resp_hit_out !== e.hit || int'(resp_way_out) != e.way || resp_data_out !== e.data ||
            resp_evict_valid_out !== e.ev || resp_evict_tag_out !== e.evt) begin
          fails++;
          $display("FAIL scoreboard_resp: got hit=%0d way=%0d data=%h ev=%0d evt=%h, want hit=%0d way=%0d data=%h ev=%0d evt=%h",
                   resp_hit_out, resp_way_out, resp_data_out, resp_evict_valid_out, resp_evict_tag_out,
                   e.hit, e.way, e.data, e.ev, e.evt);
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [7:0] mask, input int set,
                       input logic [19:0] tag, input logic [63:0] data, input bit fl);
    int guard;
    exp_t e;
    guard = 0;
    while (!req_ready_out && guard < 300) begin
      @(negedge clk_in);
      guard++;
    end
    if (!req_ready_out) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready=%0d after %0d cycles, want 1", req_ready_out, guard);
      return;
    end
    req_valid_in      = 1'b1;
    req_write_in      = wr;
    req_write_mask_in = mask;
    req_set_addr_in   = 6'(set);
    req_tag_in        = tag;
    req_data_in       = data;
    flush_in          = fl;
    model_step(wr, mask, set, tag, data, e);
    exp_q.push_back(e);
    if (fl) model_flush();
    @(negedge clk_in);
    req_valid_in = 1'b0;
    flush_in     = 1'b0;
  endtask

  task automatic check_last(input string name, input bit hit, input int way,
                            input logic [63:0] data, input bit ev, input logic [19:0] evt);
    #1;
    tests++;
    if (last_hit !== hit || last_way != way || last_data !== data || last_ev !== ev || last_evt !== evt) begin
      fails++;
      $display("FAIL %s: got hit=%0d way=%0d data=%h ev=%0d evt=%h, want hit=%0d way=%0d data=%h ev=%0d evt=%h",
               name, last_hit, last_way, last_data, last_ev, last_evt, hit, way, data, ev, evt);
    end
  endtask

  // Counts not-ready cycles from now until ready; optionally pulses flush_in mid-sweep.
  task automatic flush_len_check(input string name, input int pulse_at);
    int cnt;
    cnt = 0;
    while (!req_ready_out && cnt < 200) begin
      flush_in = (cnt == pulse_at);
      @(negedge clk_in);
      cnt++;
    end
    flush_in = 1'b0;
    tests++;
    if (cnt != 64) begin
      fails++;
      $display("FAIL %s: not-ready cycles got %0d, want 64", name, cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_in = 1'b0; flush_in = 1'b0; req_valid_in = 1'b0; req_write_in = 1'b0;
    req_write_mask_in = '0; req_set_addr_in = '0; req_tag_in = '0; req_data_in = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    tests++;
    if (req_ready_out !== 1'b0 || resp_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%0d resp_valid=%0d, want 0 0", req_ready_out, resp_valid_out);
    end
    reset_n_in = 1'b1;
    req_valid_in = 1'b1;  // held during the sweep; must not be accepted
    flush_len_check("reset_flush_len", -1);
    req_valid_in = 1'b0;

    issue(0, 8'h00, 5, 20'h123, '0, 0);
    check_last("lookup_after_reset", 0, 0, '0, 0, '0);

    issue(1, 8'hFF, 5, 20'h123, 64'hA5A5_A5A5_A5A5_A5A5, 0);
    issue(0, 8'h00, 5, 20'h123, '0, 0);
    check_last("lookup_after_write", 1, 0, 64'hA5A5_A5A5_A5A5_A5A5, 0, '0);

    issue(1, 8'h01, 5, 20'h123, 64'h0000_0000_0000_00FF, 0);
    check_last("write_hit_resp", 1, 0, '0, 0, '0);
    issue(0, 8'h00, 5, 20'h123, '0, 0);
    check_last("masked_write_hit", 1, 0, 64'hA5A5_A5A5_A5A5_A5FF, 0, '0);

    for (int t = 1; t <= 4; t++) issue(1, 8'hFF, 7, 20'(t), 64'(t) * 64'h1111, 0);
    issue(1, 8'h0F, 7, 20'h5, 64'hDEAD_BEEF_CAFE_F00D, 0);
    check_last("evict_first", 0, 0, '0, 1, 20'h1);
    issue(1, 8'hFF, 7, 20'h6, 64'h6666, 0);
    check_last("evict_second", 0, 1, '0, 1, 20'h2);
    issue(0, 8'h00, 7, 20'h5, '0, 0);
    check_last("miss_alloc_zero_fill", 1, 0, 64'h0000_0000_CAFE_F00D, 0, '0);

    // Flush with a concurrent write-miss; a second flush pulse mid-sweep is ignored.
    issue(1, 8'hFF, 9, 20'h77, 64'h1234, 1);
    check_last("flush_concurrent_write", 0, 0, '0, 0, '0);
    flush_len_check("flush_len", 10);
    issue(0, 8'h00, 9, 20'h77, '0, 0);
    check_last("after_flush_miss_new", 0, 0, '0, 0, '0);
    issue(0, 8'h00, 5, 20'h123, '0, 0);
    check_last("after_flush_miss_old", 0, 0, '0, 0, '0);
    // RR pointer of set 7 survives flush: refill and evict lands on way 2.
    for (int t = 1; t <= 4; t++) issue(1, 8'hFF, 7, 20'(t + 16), 64'(t), 0);
    issue(1, 8'hFF, 7, 20'h30, 64'h30, 0);
    check_last("rr_survives_flush", 0, 2, '0, 1, 20'h13);

    // Reset in the middle of a sweep restarts it from set 0.
    issue(0, 8'h00, 0, 20'h0, '0, 1);
    repeat (30) @(negedge clk_in);
    reset_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    model_reset();
    reset_n_in = 1'b1;
    flush_len_check("reset_mid_flush_len", -1);
    issue(0, 8'h00, 7, 20'h30, '0, 0);
    check_last("after_reset_miss", 0, 0, '0, 0, '0);

    for (int i = 0; i < 600; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)),
            20'($urandom_range(0, 7)), {$urandom, $urandom}, ($urandom_range(0, 99) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk_in);
    end

    repeat (3) @(negedge clk_in);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_responses: %0d outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
